// File: rtl/pcie_axi_dma_desc_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_axi_dma_desc_demux_pkg
// Description : Helpers shared by the descriptor demux and its status FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_axi_dma_desc_demux_pkg;

  // Select field width: clog2 of the port count, never narrower than one bit
  function automatic int sel_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // Port index reached by stepping offset places from start, wrapping at n
  function automatic int rr_index(input int start, input int offset, input int n);
    int s;
    s = start + offset;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_axi_dma_status_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pcie_axi_dma_status_fifo
// Description : Small per-engine status FIFO. Writes cannot be back-pressured,
//               so a write into a full FIFO that is not popped that cycle is
//               dropped and flagged with a single-cycle overflow pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_axi_dma_status_fifo
  import pcie_axi_dma_desc_demux_pkg::*;
#(
  parameter int TAG_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [3:0]           wr_error,
  input  logic                 rd_en,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic [3:0]           rd_error,
  output logic                 empty,
  output logic                 overflow
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_PW = C_AW + 1;

  logic [TAG_WIDTH+3:0] r_mem [DEPTH];
  logic [C_PW-1:0]      r_wr_ptr;
  logic [C_PW-1:0]      r_rd_ptr;
  logic                 w_full;
  logic                 w_do_wr;
  logic                 w_do_rd;

  // Extra pointer MSB distinguishes full from empty when the addresses match
  assign w_full   = (r_wr_ptr[C_PW-1] != r_rd_ptr[C_PW-1]) &&
                    (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign empty    = (r_wr_ptr == r_rd_ptr);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_do_wr  = wr_en && (!w_full || rd_en);
  assign w_do_rd  = rd_en && !empty;
  assign overflow = wr_en && w_full && !rd_en;

  assign {rd_tag, rd_error} = r_mem[r_rd_ptr[C_AW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write, intentionally without reset
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[C_AW-1:0]] <= {wr_tag, wr_error};
  end

endmodule
`default_nettype wire

// File: rtl/pcie_axi_dma_desc_demux.sv
`default_nettype none
// ============================================================================
// Module      : pcie_axi_dma_desc_demux
// Description : Routes one descriptor stream to PORTS DMA engines by select
//               field and merges their status pulses back through per-port
//               FIFOs and a round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_axi_dma_desc_demux
  import pcie_axi_dma_desc_demux_pkg::*;
#(
  parameter int PORTS             = 2,
  parameter int PCIE_ADDR_WIDTH   = 64,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH         = 20,
  parameter int TAG_WIDTH         = 8,
  parameter int SEL_WIDTH         = sel_width(PORTS),
  parameter int STATUS_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PCIE_ADDR_WIDTH-1:0]         s_axis_desc_pcie_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axis_desc_axi_addr,
  input  logic [LEN_WIDTH-1:0]               s_axis_desc_len,
  input  logic [TAG_WIDTH-1:0]               s_axis_desc_tag,
  input  logic [SEL_WIDTH-1:0]               s_axis_desc_sel,
  input  logic                               s_axis_desc_valid,
  output logic                               s_axis_desc_ready,
  output logic [PORTS*PCIE_ADDR_WIDTH-1:0]   m_axis_desc_pcie_addr,
  output logic [PORTS*AXI_ADDR_WIDTH-1:0]    m_axis_desc_axi_addr,
  output logic [PORTS*LEN_WIDTH-1:0]         m_axis_desc_len,
  output logic [PORTS*TAG_WIDTH-1:0]         m_axis_desc_tag,
  output logic [PORTS-1:0]                   m_axis_desc_valid,
  input  logic [PORTS-1:0]                   m_axis_desc_ready,
  input  logic [PORTS*TAG_WIDTH-1:0]         s_axis_desc_status_tag,
  input  logic [PORTS*4-1:0]                 s_axis_desc_status_error,
  input  logic [PORTS-1:0]                   s_axis_desc_status_valid,
  output logic [TAG_WIDTH-1:0]               m_axis_desc_status_tag,
  output logic [3:0]                         m_axis_desc_status_error,
  output logic                               m_axis_desc_status_valid,
  output logic [SEL_WIDTH-1:0]               m_axis_desc_status_port,
  output logic                               desc_drop,
  output logic [PORTS-1:0]                   status_overflow
);

  // ---------------- descriptor path ----------------
  logic [PCIE_ADDR_WIDTH-1:0] r_pcie_addr;
  logic [AXI_ADDR_WIDTH-1:0]  r_axi_addr;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [TAG_WIDTH-1:0]       r_tag;
  logic [PORTS-1:0]           r_desc_valid;
  logic                       r_desc_drop;
  logic                       w_held_ready;
  logic                       w_accept;
  logic                       w_sel_ok;
  logic [PORTS-1:0]           w_sel_onehot;

  // Valid is one-hot, so this only ever reflects the held port's ready
  assign w_held_ready      = |(r_desc_valid & m_axis_desc_ready);
  assign s_axis_desc_ready = !rst && (!(|r_desc_valid) || w_held_ready);
  assign w_accept          = s_axis_desc_valid && s_axis_desc_ready;
  assign w_sel_ok          = 32'(s_axis_desc_sel) < PORTS;

  // Decode the select field into the destination valid bit
  always_comb begin
    w_sel_onehot = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_sel_onehot[i] = (32'(s_axis_desc_sel) == i);
    end
  end

  // Valid/drop control: load on accept, clear once the held port takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desc_valid <= '0;
      r_desc_drop  <= 1'b0;
    end else begin
      r_desc_drop <= w_accept && !w_sel_ok;
      if (w_accept) begin
        r_desc_valid <= w_sel_ok ? w_sel_onehot : '0;
      end else if (w_held_ready) begin
        r_desc_valid <= '0;
      end
    end
  end

  // Shared descriptor fields, loaded only for descriptors that will be sent
  always_ff @(posedge clk) begin
    if (w_accept && w_sel_ok) begin
      r_pcie_addr <= s_axis_desc_pcie_addr;
      r_axi_addr  <= s_axis_desc_axi_addr;
      r_len       <= s_axis_desc_len;
      r_tag       <= s_axis_desc_tag;
    end
  end

  assign m_axis_desc_pcie_addr = {PORTS{r_pcie_addr}};
  assign m_axis_desc_axi_addr  = {PORTS{r_axi_addr}};
  assign m_axis_desc_len       = {PORTS{r_len}};
  assign m_axis_desc_tag       = {PORTS{r_tag}};
  assign m_axis_desc_valid     = r_desc_valid;
  assign desc_drop             = r_desc_drop;

  // ---------------- status path ----------------
  logic [TAG_WIDTH-1:0] w_fifo_tag   [PORTS];
  logic [3:0]           w_fifo_error [PORTS];
  logic [PORTS-1:0]     w_empty;
  logic [PORTS-1:0]     w_grant;
  logic                 w_grant_any;
  logic [SEL_WIDTH-1:0] w_grant_idx;
  logic [TAG_WIDTH-1:0] w_pop_tag;
  logic [3:0]           w_pop_error;
  logic                 r_st_valid;
  logic [TAG_WIDTH-1:0] r_st_tag;
  logic [3:0]           r_st_error;
  logic [SEL_WIDTH-1:0] r_st_port;

  for (genvar i = 0; i < PORTS; i++) begin : g_fifo
    pcie_axi_dma_status_fifo #(
      .TAG_WIDTH (TAG_WIDTH),
      .DEPTH     (STATUS_FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (s_axis_desc_status_valid[i]),
      .wr_tag   (s_axis_desc_status_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .wr_error (s_axis_desc_status_error[i*4 +: 4]),
      .rd_en    (w_grant[i]),
      .rd_tag   (w_fifo_tag[i]),
      .rd_error (w_fifo_error[i]),
      .empty    (w_empty[i]),
      .overflow (status_overflow[i])
    );
  end

  if (PORTS == 1) begin : g_single
    assign w_grant     = ~w_empty;
    assign w_grant_any = !w_empty[0];
    assign w_grant_idx = '0;
    assign w_pop_tag   = w_fifo_tag[0];
    assign w_pop_error = w_fifo_error[0];
  end else begin : g_rr
    logic [SEL_WIDTH-1:0] r_rr_start;
    int                   w_rr_idx;

    // Scan from highest to lowest offset so the nearest non-empty port wins
    always_comb begin
      w_grant     = '0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_pop_tag   = '0;
      w_pop_error = '0;
      w_rr_idx    = 0;
      for (int k = PORTS - 1; k >= 0; k--) begin
        w_rr_idx = rr_index(int'(r_rr_start), k, PORTS);
        if (!w_empty[w_rr_idx]) begin
          w_grant           = '0;
          w_grant[w_rr_idx] = 1'b1;
          w_grant_any       = 1'b1;
          w_grant_idx       = SEL_WIDTH'(w_rr_idx);
          w_pop_tag         = w_fifo_tag[w_rr_idx];
          w_pop_error       = w_fifo_error[w_rr_idx];
        end
      end
    end

    // Priority moves to the port after the one just granted
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rr_start <= '0;
      end else if (w_grant_any) begin
        r_rr_start <= SEL_WIDTH'(rr_index(int'(w_grant_idx), 1, PORTS));
      end
    end
  end

  // Merged status valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_valid <= 1'b0;
    end else begin
      r_st_valid <= w_grant_any;
    end
  end

  // Merged status payload, captured with the popped entry
  always_ff @(posedge clk) begin
    if (w_grant_any) begin
      r_st_tag   <= w_pop_tag;
      r_st_error <= w_pop_error;
      r_st_port  <= w_grant_idx;
    end
  end

  assign m_axis_desc_status_valid = r_st_valid;
  assign m_axis_desc_status_tag   = r_st_tag;
  assign m_axis_desc_status_error = r_st_error;
  assign m_axis_desc_status_port  = r_st_port;

endmodule
`default_nettype wire

// File: tb/tb_pcie_axi_dma_desc_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_axi_dma_desc_demux
// Description : Scoreboard bench for the descriptor demux / status merger,
//               three ports with a four-entry status FIFO per port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_axi_dma_desc_demux;

  localparam int PORTS = 3;
  localparam int SEL_W = 2;
  localparam int PA    = 64;
  localparam int AA    = 16;
  localparam int LW    = 20;
  localparam int TW    = 8;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PA-1:0]       s_pcie;
  logic [AA-1:0]       s_axi;
  logic [LW-1:0]       s_len;
  logic [TW-1:0]       s_tag;
  logic [SEL_W-1:0]    s_sel;
  logic                s_valid;
  logic                s_ready;
  logic [PORTS*PA-1:0] m_pcie;
  logic [PORTS*AA-1:0] m_axi;
  logic [PORTS*LW-1:0] m_len;
  logic [PORTS*TW-1:0] m_tag;
  logic [PORTS-1:0]    m_valid;
  logic [PORTS-1:0]    m_ready;
  logic [PORTS*TW-1:0] st_in_tag;
  logic [PORTS*4-1:0]  st_in_err;
  logic [PORTS-1:0]    st_in_valid;
  logic [TW-1:0]       st_tag;
  logic [3:0]          st_err;
  logic                st_valid;
  logic [SEL_W-1:0]    st_port;
  logic                desc_drop;
  logic [PORTS-1:0]    ovf;

  always #5 clk = ~clk;

  pcie_axi_dma_desc_demux #(
    .PORTS             (PORTS),
    .PCIE_ADDR_WIDTH   (PA),
    .AXI_ADDR_WIDTH    (AA),
    .LEN_WIDTH         (LW),
    .TAG_WIDTH         (TW),
    .SEL_WIDTH         (SEL_W),
    .STATUS_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_desc_pcie_addr    (s_pcie),
    .s_axis_desc_axi_addr     (s_axi),
    .s_axis_desc_len          (s_len),
    .s_axis_desc_tag          (s_tag),
    .s_axis_desc_sel          (s_sel),
    .s_axis_desc_valid        (s_valid),
    .s_axis_desc_ready        (s_ready),
    .m_axis_desc_pcie_addr    (m_pcie),
    .m_axis_desc_axi_addr     (m_axi),
    .m_axis_desc_len          (m_len),
    .m_axis_desc_tag          (m_tag),
    .m_axis_desc_valid        (m_valid),
    .m_axis_desc_ready        (m_ready),
    .s_axis_desc_status_tag   (st_in_tag),
    .s_axis_desc_status_error (st_in_err),
    .s_axis_desc_status_valid (st_in_valid),
    .m_axis_desc_status_tag   (st_tag),
    .m_axis_desc_status_error (st_err),
    .m_axis_desc_status_valid (st_valid),
    .m_axis_desc_status_port  (st_port),
    .desc_drop                (desc_drop),
    .status_overflow          (ovf)
  );

  typedef struct packed {
    logic [SEL_W-1:0] port;
    logic [PA-1:0]    pcie;
    logic [AA-1:0]    axi;
    logic [LW-1:0]    len;
    logic [TW-1:0]    tag;
  } desc_t;

  typedef struct packed {
    logic [SEL_W-1:0] port;
    logic [TW-1:0]    tag;
    logic [3:0]       err;
  } st_t;

  desc_t desc_q[$];
  st_t   st_q[$];
  int    n_vec     = 0;
  int    n_err     = 0;
  int    drop_seen = 0;
  int    drop_exp  = 0;
  int    cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] err_of(input logic [TW-1:0] t);
    return t[3:0] ^ 4'hA;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input logic [SEL_W-1:0] p, input logic [TW-1:0] t);
    st_q.push_back('{port: p, tag: t, err: err_of(t)});
  endtask

  task automatic drive_desc(input logic [SEL_W-1:0] sel, input logic [PA-1:0] pa,
                            input logic [AA-1:0] aa, input logic [LW-1:0] len,
                            input logic [TW-1:0] tag);
    s_sel   = sel;
    s_pcie  = pa;
    s_axi   = aa;
    s_len   = len;
    s_tag   = tag;
    s_valid = 1'b1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [SEL_W-1:0] sel, input logic [PA-1:0] pa,
                       input logic [AA-1:0] aa, input logic [LW-1:0] len,
                       input logic [TW-1:0] tag, input bit push, output int waited);
    drive_desc(sel, pa, aa, len, tag);
    if (push) begin
      if (32'(sel) < PORTS) desc_q.push_back('{port: sel, pcie: pa, axi: aa, len: len, tag: tag});
      else drop_exp++;
    end
    waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: s_axis_desc_ready stayed 0 for sel %0d", sel);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // One status input cycle; checks the overflow vector in that cycle
  task automatic st_cycle(input logic [PORTS-1:0] v, input logic [TW-1:0] t0,
                          input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                          input logic [PORTS-1:0] exp_ovf);
    st_in_valid = v;
    st_in_tag   = {t2, t1, t0};
    st_in_err   = {err_of(t2), err_of(t1), err_of(t0)};
    @(negedge clk);
    chk("status_overflow", 64'(ovf), 64'(exp_ovf));
    @(posedge clk);
    #1;
    st_in_valid = '0;
  endtask

  // Descriptor and status monitors
  always @(negedge clk) begin : mon
    desc_t de;
    st_t   se;
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        if (m_valid[p] && m_ready[p]) begin
          if (desc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL desc_unexpected: port %0d handshake tag %0h, expected none", p, m_tag[p*TW +: TW]);
          end else begin
            de = desc_q.pop_front();
            chk("desc_port", 64'(p), 64'(de.port));
            chk("desc_pcie", 64'(m_pcie[p*PA +: PA]), 64'(de.pcie));
            chk("desc_axi", 64'(m_axi[p*AA +: AA]), 64'(de.axi));
            chk("desc_len", 64'(m_len[p*LW +: LW]), 64'(de.len));
            chk("desc_tag", 64'(m_tag[p*TW +: TW]), 64'(de.tag));
          end
        end
      end
      if (st_valid) begin
        if (st_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL status_unexpected: port %0d tag %0h, expected none", st_port, st_tag);
        end else begin
          se = st_q.pop_front();
          chk("status_port", 64'(st_port), 64'(se.port));
          chk("status_tag", 64'(st_tag), 64'(se.tag));
          chk("status_error", 64'(st_err), 64'(se.err));
        end
      end
      if (desc_drop) drop_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int c0;
    s_valid     = 1'b0;
    s_sel       = '0;
    s_pcie      = '0;
    s_axi       = '0;
    s_len       = '0;
    s_tag       = '0;
    m_ready     = '1;
    st_in_valid = '0;
    st_in_tag   = '0;
    st_in_err   = '0;

    // Reset state
    #2;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_st_valid", 64'(st_valid), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 64'(1));
    chk("post_rst_drop", 64'(desc_drop), 64'(0));
    chk("post_rst_ovf", 64'(ovf), 64'(0));
    tick();

    // Single descriptor to port 2, one-cycle latency
    issue(2'd2, 64'h1122_3344_5566_7788, 16'hBEEF, 20'h00100, 8'h5A, 1'b1, w);
    @(negedge clk);
    chk("d1_valid", 64'(m_valid), 64'(3'b100));
    chk("d1_tag", 64'(m_tag[2*TW +: TW]), 64'(8'h5A));
    chk("d1_len", 64'(m_len[2*LW +: LW]), 64'(20'h00100));
    tick();

    // Back-to-back descriptors, one per cycle
    c0 = cyc;
    issue(2'd0, 64'hA000_0000_0000_0000, 16'h0001, 20'h00010, 8'h01, 1'b1, w);
    chk("b2b0_wait", 64'(w), 64'(0));
    issue(2'd1, 64'hA000_0000_0000_0001, 16'h0002, 20'h00020, 8'h02, 1'b1, w);
    chk("b2b1_wait", 64'(w), 64'(0));
    issue(2'd2, 64'hA000_0000_0000_0002, 16'h0003, 20'h00030, 8'h03, 1'b1, w);
    chk("b2b2_wait", 64'(w), 64'(0));
    chk("b2b_cycles", 64'(cyc - c0), 64'(3));
    @(negedge clk);
    chk("b2b_last_valid", 64'(m_valid), 64'(3'b100));
    tick();

    // Held descriptor on port 1 while its ready is low
    m_ready = 3'b101;
    issue(2'd1, 64'hCAFE_0000_0000_1111, 16'h1111, 20'h11111, 8'h31, 1'b1, w);
    drive_desc(2'd0, 64'hCAFE_0000_0000_2222, 16'h2222, 20'h22222, 8'h32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s_ready", 64'(s_ready), 64'(0));
      chk("hold_valid", 64'(m_valid), 64'(3'b010));
      chk("hold_tag", 64'(m_tag[1*TW +: TW]), 64'(8'h31));
      chk("hold_pcie", 64'(m_pcie[1*PA +: PA]), 64'hCAFE_0000_0000_1111);
      tick();
    end
    m_ready = 3'b111;
    issue(2'd0, 64'hCAFE_0000_0000_2222, 16'h2222, 20'h22222, 8'h32, 1'b1, w);
    chk("release_wait", 64'(w), 64'(0));
    @(negedge clk);
    chk("next_valid", 64'(m_valid), 64'(3'b001));
    chk("next_tag", 64'(m_tag[0*TW +: TW]), 64'(8'h32));
    tick();

    // Out-of-range select is dropped
    issue(2'd3, 64'hDEAD_0000_0000_0003, 16'h3333, 20'h00333, 8'h33, 1'b1, w);
    @(negedge clk);
    chk("drop_pulse", 64'(desc_drop), 64'(1));
    chk("drop_no_valid", 64'(m_valid), 64'(0));
    tick();
    issue(2'd0, 64'hBEEF_0000_0000_0034, 16'h3434, 20'h00034, 8'h34, 1'b1, w);
    @(negedge clk);
    chk("after_drop_valid", 64'(m_valid), 64'(3'b001));
    chk("after_drop_pulse", 64'(desc_drop), 64'(0));
    tick();

    // Simultaneous status from reset priority: order 0,1,2, two-cycle latency
    exp_st(2'd0, 8'h10);
    exp_st(2'd1, 8'h11);
    exp_st(2'd2, 8'h12);
    st_cycle(3'b111, 8'h10, 8'h11, 8'h12, 3'b000);
    @(negedge clk);
    chk("st_lat_t1", 64'(st_valid), 64'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_seq_valid", 64'(st_valid), 64'(1));
      chk("st_seq_port", 64'(st_port), 64'(i));
      tick();
    end
    repeat (3) tick();

    // Move priority to port 1, then simultaneous status: order 1,2,0
    exp_st(2'd0, 8'h40);
    st_cycle(3'b001, 8'h40, 8'h00, 8'h00, 3'b000);
    repeat (4) tick();
    exp_st(2'd1, 8'h51);
    exp_st(2'd2, 8'h52);
    exp_st(2'd0, 8'h50);
    st_cycle(3'b111, 8'h50, 8'h51, 8'h52, 3'b000);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rr1_first_port", 64'(st_port), 64'(1));
    tick();
    repeat (4) tick();
    // Grant port 2 alone so priority returns to port 0
    exp_st(2'd2, 8'h60);
    st_cycle(3'b100, 8'h00, 8'h00, 8'h60, 3'b000);
    repeat (4) tick();

    // Port 0 flooded, ports 1/2 alternating: one overflow on port 0 only
    exp_st(2'd0, 8'h00); exp_st(2'd1, 8'h10); exp_st(2'd2, 8'h20);
    exp_st(2'd0, 8'h01); exp_st(2'd1, 8'h11); exp_st(2'd2, 8'h21);
    exp_st(2'd0, 8'h02); exp_st(2'd1, 8'h12); exp_st(2'd2, 8'h22);
    exp_st(2'd0, 8'h03); exp_st(2'd1, 8'h13); exp_st(2'd2, 8'h23);
    exp_st(2'd0, 8'h04); exp_st(2'd0, 8'h05); exp_st(2'd0, 8'h07);
    st_cycle(3'b011, 8'h00, 8'h10, 8'h00, 3'b000);
    st_cycle(3'b101, 8'h01, 8'h00, 8'h20, 3'b000);
    st_cycle(3'b011, 8'h02, 8'h11, 8'h00, 3'b000);
    st_cycle(3'b101, 8'h03, 8'h00, 8'h21, 3'b000);
    st_cycle(3'b011, 8'h04, 8'h12, 8'h00, 3'b000);
    st_cycle(3'b101, 8'h05, 8'h00, 8'h22, 3'b000);
    st_cycle(3'b011, 8'h06, 8'h13, 8'h00, 3'b001);
    st_cycle(3'b101, 8'h07, 8'h00, 8'h23, 3'b000);
    repeat (20) tick();
    chk("flood_drained", 64'(st_q.size()), 64'(0));

    // Asynchronous reset with a held descriptor and queued status
    m_ready = 3'b101;
    issue(2'd1, 64'h5757_0000_0000_0077, 16'h7777, 20'h00777, 8'h77, 1'b0, w);
    st_cycle(3'b011, 8'h80, 8'h81, 8'h00, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'(0));
    chk("arst_st_valid", 64'(st_valid), 64'(0));
    chk("arst_s_ready", 64'(s_ready), 64'(0));
    chk("arst_drop", 64'(desc_drop), 64'(0));
    chk("arst_ovf", 64'(ovf), 64'(0));
    tick();
    tick();
    m_ready = 3'b111;
    rst     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_arst_m_valid", 64'(m_valid), 64'(0));
      chk("post_arst_st_valid", 64'(st_valid), 64'(0));
      tick();
    end

    // Normal operation resumes after reset
    issue(2'd0, 64'h0000_0000_0000_00A0, 16'h00A0, 20'h000A0, 8'hA0, 1'b1, w);
    exp_st(2'd1, 8'h99);
    st_cycle(3'b010, 8'h00, 8'h99, 8'h00, 3'b000);
    repeat (6) tick();

    chk("desc_q_empty", 64'(desc_q.size()), 64'(0));
    chk("st_q_empty", 64'(st_q.size()), 64'(0));
    chk("drop_count", 64'(drop_seen), 64'(drop_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
